// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer slice: RV32 major opcodes and FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// The custom MAC instruction lives on opcode 7'b1111111 alongside the base RV32 opcodes.
package mac_sequencer_pkg;

  // RV32 major opcodes
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MAC      = 7'b1111111;  // rd = rd + rs1*rs2

  // Sequencer FSM encoding (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mac_shift_add.sv
// Radix-2 shift-add datapath: one multiplier bit consumed per step, product accumulated in place.
// Latency: load takes one edge; each step one edge; last_o/zero_o reflect the current iteration.
// Backpressure: none; the controller gates load_i/step_i.
//
// Ports: clk/reset (sync, active-high); load_i latches mcand_i/mplier_i/acc_i and clears the count;
// step_i performs one iteration; prod_next_o is the product after the current iteration;
// last_o flags the XLEN-th iteration; zero_o flags an exhausted multiplier (MAC_EARLY_TERM_EN only).
module mac_shift_add #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0] mplier_i,
  input  logic [XLEN-1:0] acc_i,
  output logic [XLEN-1:0] prod_next_o,
  output logic            last_o,
  output logic            zero_o
);

  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  prod_step;

  // Carry out of the add is dropped: only the low XLEN bits of rd + rs1*rs2 are architectural.
  assign prod_step   = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_next_o = prod_step;
  assign last_o      = (cnt_q == CNT_W'(XLEN - 1));

`ifdef MAC_EARLY_TERM_EN
  // Looks at the multiplier as it will be after this iteration's shift.
  assign zero_o = (mplier_q[XLEN-1:1] == '0);
`else
  assign zero_o = 1'b0;
`endif

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      prod_d   = acc_i;
      cnt_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = prod_step;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Multi-cycle MAC sequencer beside EX: rd = rd + rs1*rs2 (low XLEN bits) via shift-add.
// Latency: start in cycle 0, RUN cycles 1..XLEN, one-cycle write request in cycle XLEN+1.
// Backpressure: stall freezes ID/IF from the accepting cycle through the last RUN cycle; flush aborts.
//
// Ports: clk/reset (sync, active-high); start/flush from EX control; rs1_val, rs2_val, acc_val, rd_in
// operands; stall, busy status; result_valid/result/result_rd write request to the writeback mux.
// Option: define MAC_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] acc_val,
  input  logic [4:0]      rd_in,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  state_t          state_q, state_d;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      result_rd_q;

  logic            accept;
  logic            step;
  logic            finish;
  logic [XLEN-1:0] prod_next;
  logic            last;
  logic            zero;

  // Flush wins over a same-cycle start; start outside IDLE is ignored since upstream is stalled.
  assign accept = (state_q == ST_IDLE) && start && !flush;
  assign step   = (state_q == ST_RUN) && !flush;
  assign finish = step && (last || zero);

  mac_shift_add #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_shift_add (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .step_i      (step),
    .mcand_i     (rs1_val),
    .mplier_i    (rs2_val),
    .acc_i       (acc_val),
    .prod_next_o (prod_next),
    .last_o      (last),
    .zero_o      (zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)       state_d = ST_IDLE;
        else if (finish) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The output registers capture the final product on the last RUN edge, so result stays
  // stable after DONE even though the datapath may be reloaded by the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      result_q    <= '0;
      result_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) rd_q <= rd_in;
      if (finish) begin
        result_q    <= prod_next;
        result_rd_q <= rd_q;
      end
    end
  end

  // Stall drops in DONE so the pipeline advances during the writeback cycle.
  assign stall        = accept || (state_q == ST_RUN);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE) && !flush;
  assign result       = result_q;
  assign result_rd    = result_rd_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: timing, arithmetic wrap, flush, reset and back-to-back issue.
// Latency: n/a.
// Backpressure: n/a.
module tb_mac_sequencer;

  localparam int XLEN = 32;
  localparam int NCYC = 80;

  logic            clk = 1'b0;
  logic            reset, start, flush;
  logic [XLEN-1:0] rs1_val, rs2_val, acc_val;
  logic [4:0]      rd_in;
  logic            stall, busy, result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_rd;

  int n_cmp = 0;
  int n_err = 0;

  logic            cap_stall [NCYC];
  logic            cap_busy  [NCYC];
  logic            cap_rv    [NCYC];
  logic [XLEN-1:0] cap_res   [NCYC];
  logic [4:0]      cap_rd    [NCYC];
  int              cap_nrv, cap_rv1, cap_rv2;
  logic [XLEN-1:0] cap_res1, cap_res2;
  logic [4:0]      cap_rd1;

  mac_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .acc_val      (acc_val),
    .rd_in        (rd_in),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .result_rd    (result_rd)
  );

  always #5 clk = ~clk;

  // Cycle at which result_valid is expected, counting the accepting cycle as 0.
  function automatic int exp_done(input logic [XLEN-1:0] rs2);
    int hb;
    hb = 1;
`ifdef MAC_EARLY_TERM_EN
    for (int i = 0; i < XLEN; i++) if (rs2[i]) hb = i + 1;
`else
    hb = XLEN;
`endif
    return hb + 1;
  endfunction

  // Drives one operation for NCYC cycles and records the outputs of every cycle.
  task automatic drive_op(input logic [XLEN-1:0] acc, input logic [XLEN-1:0] m1,
                          input logic [XLEN-1:0] m2, input logic [4:0] rd,
                          input int start_last, input int flush_at, input int reset_at);
    cap_nrv = 0; cap_rv1 = -1; cap_rv2 = -1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      start = (c <= start_last); flush = (c == flush_at); reset = (c == reset_at);
      acc_val = acc; rs1_val = m1; rs2_val = m2; rd_in = rd;
      #1;
      cap_stall[c] = stall; cap_busy[c] = busy; cap_rv[c] = result_valid;
      cap_res[c] = result; cap_rd[c] = result_rd;
      if (result_valid === 1'b1) begin
        cap_nrv++;
        if (cap_rv1 < 0) begin
          cap_rv1 = c; cap_res1 = result; cap_rd1 = result_rd;
        end else if (cap_rv2 < 0) begin
          cap_rv2 = c; cap_res2 = result;
        end
      end
    end
    start = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    rs1_val = '0; rs2_val = '0; acc_val = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", stall); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got=%b want=0", result_valid); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got=%h want=0", result); end
    n_cmp++; if (result_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd got=%0d want=0", result_rd); end
    reset = 1'b0;
  endtask

  task automatic test_mac(input string name, input logic [XLEN-1:0] acc, input logic [XLEN-1:0] m1,
                          input logic [XLEN-1:0] m2, input logic [4:0] rd, input logic [XLEN-1:0] want);
    int d;
    d = exp_done(m2);
    drive_op(acc, m1, m2, rd, 0, -1, -1);
    n_cmp++; if (cap_nrv !== 1) begin n_err++; $display("FAIL %s_nrv got=%0d want=1", name, cap_nrv); end
    n_cmp++; if (cap_rv1 !== d) begin n_err++; $display("FAIL %s_rv_cycle got=%0d want=%0d", name, cap_rv1, d); end
    n_cmp++; if (cap_res1 !== want) begin n_err++; $display("FAIL %s_result got=%h want=%h", name, cap_res1, want); end
    n_cmp++; if (cap_rd1 !== rd) begin n_err++; $display("FAIL %s_rd got=%0d want=%0d", name, cap_rd1, rd); end
    for (int c = 0; c <= d + 2; c++) begin
      n_cmp++;
      if (cap_stall[c] !== (c < d)) begin
        n_err++; $display("FAIL %s_stall cycle=%0d got=%b want=%b", name, c, cap_stall[c], (c < d));
      end
    end
    n_cmp++; if (cap_busy[d] !== 1'b1) begin n_err++; $display("FAIL %s_busy_done got=%b want=1", name, cap_busy[d]); end
    n_cmp++; if (cap_busy[d+1] !== 1'b0) begin n_err++; $display("FAIL %s_busy_after got=%b want=0", name, cap_busy[d+1]); end
    n_cmp++; if (cap_res[d+5] !== want) begin n_err++; $display("FAIL %s_hold got=%h want=%h", name, cap_res[d+5], want); end
  endtask

  task automatic test_flush();
    drive_op(32'd0, 32'd3, 32'hFFFF_FFFF, 5'd7, 0, 10, -1);
    n_cmp++; if (cap_nrv !== 0) begin n_err++; $display("FAIL flush_nrv got=%0d want=0", cap_nrv); end
    n_cmp++; if (cap_stall[10] !== 1'b1) begin n_err++; $display("FAIL flush_stall10 got=%b want=1", cap_stall[10]); end
    n_cmp++; if (cap_stall[11] !== 1'b0) begin n_err++; $display("FAIL flush_stall11 got=%b want=0", cap_stall[11]); end
    n_cmp++; if (cap_busy[10] !== 1'b1) begin n_err++; $display("FAIL flush_busy10 got=%b want=1", cap_busy[10]); end
    n_cmp++; if (cap_busy[11] !== 1'b0) begin n_err++; $display("FAIL flush_busy11 got=%b want=0", cap_busy[11]); end
  endtask

  task automatic test_flush_start();
    drive_op(32'd1, 32'd1, 32'd1, 5'd4, 0, 0, -1);
    n_cmp++; if (cap_stall[0] !== 1'b0) begin n_err++; $display("FAIL fstart_stall got=%b want=0", cap_stall[0]); end
    n_cmp++; if (cap_busy[1] !== 1'b0) begin n_err++; $display("FAIL fstart_busy got=%b want=0", cap_busy[1]); end
    n_cmp++; if (cap_nrv !== 0) begin n_err++; $display("FAIL fstart_nrv got=%0d want=0", cap_nrv); end
  endtask

  task automatic test_back_to_back();
    int d;
    d = exp_done(32'd6);
    // start held high through RUN and DONE, and still high the cycle after DONE
    drive_op(32'd1, 32'd5, 32'd6, 5'd9, d + 1, -1, -1);
    n_cmp++; if (cap_nrv !== 2) begin n_err++; $display("FAIL b2b_nrv got=%0d want=2", cap_nrv); end
    n_cmp++; if (cap_rv1 !== d) begin n_err++; $display("FAIL b2b_rv1 got=%0d want=%0d", cap_rv1, d); end
    n_cmp++; if (cap_rv2 - cap_rv1 !== d + 1) begin n_err++; $display("FAIL b2b_spacing got=%0d want=%0d", cap_rv2 - cap_rv1, d + 1); end
    n_cmp++; if (cap_res1 !== 32'd31) begin n_err++; $display("FAIL b2b_res1 got=%h want=%h", cap_res1, 32'd31); end
    n_cmp++; if (cap_res2 !== 32'd31) begin n_err++; $display("FAIL b2b_res2 got=%h want=%h", cap_res2, 32'd31); end
  endtask

  task automatic test_reset_mid();
    int bad_ctl, bad_res, bad_rd;
    bad_ctl = 0; bad_res = 0; bad_rd = 0;
    drive_op(32'd0, 32'd3, 32'h8000_0000, 5'd3, 0, -1, 5);
    for (int c = 6; c < NCYC; c++) begin
      if (cap_stall[c] !== 1'b0 || cap_busy[c] !== 1'b0 || cap_rv[c] !== 1'b0) bad_ctl++;
      if (cap_res[c] !== '0) bad_res++;
      if (cap_rd[c] !== 5'd0) bad_rd++;
    end
    n_cmp++; if (cap_busy[4] !== 1'b1) begin n_err++; $display("FAIL rstmid_busy4 got=%b want=1", cap_busy[4]); end
    n_cmp++; if (bad_ctl !== 0) begin n_err++; $display("FAIL rstmid_ctl nonzero_cycles got=%0d want=0", bad_ctl); end
    n_cmp++; if (bad_res !== 0) begin n_err++; $display("FAIL rstmid_result nonzero_cycles got=%0d want=0", bad_res); end
    n_cmp++; if (bad_rd !== 0) begin n_err++; $display("FAIL rstmid_rd nonzero_cycles got=%0d want=0", bad_rd); end
    n_cmp++; if (cap_nrv !== 0) begin n_err++; $display("FAIL rstmid_nrv got=%0d want=0", cap_nrv); end
  endtask

`ifdef MAC_EARLY_TERM_EN
  task automatic test_early_term();
    drive_op(32'd2, 32'd3, 32'd5, 5'd1, 0, -1, -1);
    n_cmp++; if (cap_rv1 !== 4) begin n_err++; $display("FAIL early5_cycle got=%0d want=4", cap_rv1); end
    n_cmp++; if (cap_res1 !== 32'd17) begin n_err++; $display("FAIL early5_result got=%h want=%h", cap_res1, 32'd17); end
    drive_op(32'd9, 32'd3, 32'd0, 5'd2, 0, -1, -1);
    n_cmp++; if (cap_rv1 !== 2) begin n_err++; $display("FAIL early0_cycle got=%0d want=2", cap_rv1); end
    n_cmp++; if (cap_res1 !== 32'd9) begin n_err++; $display("FAIL early0_result got=%h want=%h", cap_res1, 32'd9); end
  endtask
`endif

  initial begin
    test_reset();
    test_mac("basic", 32'd10, 32'd3, 32'd4, 5'd13, 32'd22);
    test_mac("negmul", 32'd0, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFE);
    test_mac("wrap", 32'h8000_0000, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h8000_0000);
    test_flush();
    test_flush_start();
    test_back_to_back();
    test_reset_mid();
`ifdef MAC_EARLY_TERM_EN
    test_early_term();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
